// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32 multi-cycle controller: FSM states, opcodes,
// ALU operation and ALU B-source codes.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXECUTE  = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath /
// memory port (slave).
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic       pc_source;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       mem_to_reg;
  logic       reg_write;
  logic       retire;
  logic       trap;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
           retire, trap, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, mem_to_reg, reg_write,
           retire, trap, state
  );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags a timeout
// on the WAIT_MAX-th such cycle.
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_stall;

  assign w_stall   = i_active && !i_ready;
  // Outside a stalled access the count rests at zero, so every access starts fresh.
  assign o_timeout = w_stall && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (w_stall) r_cnt <= r_cnt + 1'b1;
    else              r_cnt <= '0;
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle RV32 datapath (R-type, ld, sd, beq) with
// Mealy ack gating on the memory states and a sticky trap state.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  state_t     r_state, w_next;
  logic [6:0] r_opcode;
  logic       w_mem_active;
  logic       w_timeout;

  assign w_mem_active = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                        (r_state == S_MEM_WR);

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_active (w_mem_active),
    .i_ready  (bus.mem_ready),
    .o_timeout(w_timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_RESET;
      r_opcode <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= bus.opcode;
    end
  end

  always_comb begin
    w_next             = r_state;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.i_or_d         = 1'b0;
    bus.ir_write       = 1'b0;
    bus.pc_write       = 1'b0;
    bus.pc_write_cond  = 1'b0;
    bus.pc_source      = 1'b0;
    bus.alu_src_a      = 1'b0;
    bus.alu_src_b      = SRCB_RS2;
    bus.alu_op         = ALU_ADD;
    bus.mem_to_reg     = 1'b0;
    bus.reg_write      = 1'b0;
    bus.retire         = 1'b0;
    bus.trap           = 1'b0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM;
        case (bus.opcode)
          OP_R:         w_next = S_EXECUTE;
          OP_LD, OP_SD: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        w_next = (r_opcode == OP_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) w_next = S_MEM_WB;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.retire     = 1'b1;
        w_next = S_FETCH;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        bus.retire    = bus.mem_ready;
        if (bus.mem_ready) w_next = S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_EXECUTE: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_FUNCT;
        w_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 1'b1;
        bus.retire        = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP: bus.trap = 1'b1;
      default: w_next = S_TRAP;
    endcase
  end

  assign bus.state = r_state;

endmodule
